// File: rtl/des_pkg.sv
// ============================================================================
// des_pkg
// Shared constants and helpers for the iterative DES round sequencer.
//   - Fixed DES widths (block, key, round key, half block, C/D half)
//   - Key-schedule rotation schedule and PC-2 selection table
//   - Sequencer state encoding
//   - 28-bit rotate helpers and a per-round shift lookup
// Bit ordering follows the DES standard: vector [1:N], bit 1 is the MSB.
// Revision: 1.0
// ============================================================================
`default_nettype none

package des_pkg;

  localparam int DES_BLK_W  = 64;
  localparam int DES_KEY_W  = 56;
  localparam int DES_RK_W   = 48;
  localparam int DES_HALF_W = 32;
  localparam int DES_CD_W   = 28;

  // Left-rotation amount applied to C/D before round r uses it (index r = 1..16).
  localparam logic [1:0] SHIFT [1:16] = '{
    2'd1, 2'd1, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2,
    2'd1, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd1
  };

  // PC-2: round-key bit i is taken from C/D bit PC2[i].
  localparam int unsigned PC2 [1:DES_RK_W] = '{
    14, 17, 11, 24,  1,  5,  3, 28, 15,  6, 21, 10,
    23, 19, 12,  4, 26,  8, 16,  7, 27, 20, 13,  2,
    41, 52, 31, 37, 47, 55, 30, 40, 51, 45, 33, 48,
    44, 49, 39, 56, 34, 53, 46, 42, 50, 36, 29, 32
  };

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ROUND = 2'd1,
    DONE  = 2'd2
  } des_state_t;

  // SHIFT[r] for r in 1..16; any other index yields no rotation.
  function automatic logic [1:0] shift_amt(input logic [4:0] r);
    logic [1:0] s;
    s = 2'd0;
    for (int i = 1; i <= 16; i++) begin
      if (r == 5'(i)) s = SHIFT[i];
    end
    return s;
  endfunction

  function automatic logic [1:DES_CD_W] rotl28(input logic [1:DES_CD_W] x,
                                               input logic [1:0]        n);
    case (n)
      2'd1:    return {x[2:DES_CD_W], x[1]};
      2'd2:    return {x[3:DES_CD_W], x[1:2]};
      default: return x;
    endcase
  endfunction

  function automatic logic [1:DES_CD_W] rotr28(input logic [1:DES_CD_W] x,
                                               input logic [1:0]        n);
    case (n)
      2'd1:    return {x[DES_CD_W], x[1:DES_CD_W-1]};
      2'd2:    return {x[DES_CD_W-1:DES_CD_W], x[1:DES_CD_W-2]};
      default: return x;
    endcase
  endfunction

endpackage

`default_nettype wire

// File: rtl/des_key_sched_step.sv
// ============================================================================
// des_key_sched_step
// One combinational key-schedule step: PC-2 of the current C/D register and
// the C/D value for the next round (each 28-bit half rotated independently).
// Ports:
//   cd       in  [1:56] current C/D (C = [1:28], D = [29:56])
//   shift    in  [1:0]  rotation amount (0, 1 or 2)
//   decrypt  in  1      0 = rotate left (encrypt), 1 = rotate right (decrypt)
//   cd_next  out [1:56] rotated C/D
//   rk       out [1:48] round key PC2(cd)
// Revision: 1.0
// ============================================================================
`default_nettype none

module des_key_sched_step
  import des_pkg::*;
(
  input  logic [1:DES_KEY_W] cd,
  input  logic [1:0]         shift,
  input  logic               decrypt,
  output logic [1:DES_KEY_W] cd_next,
  output logic [1:DES_RK_W]  rk
);

  always_comb begin
    if (decrypt) begin
      cd_next = {rotr28(cd[1:DES_CD_W], shift), rotr28(cd[DES_CD_W+1:DES_KEY_W], shift)};
    end else begin
      cd_next = {rotl28(cd[1:DES_CD_W], shift), rotl28(cd[DES_CD_W+1:DES_KEY_W], shift)};
    end
  end

  always_comb begin
    rk = '0;
    for (int i = 1; i <= DES_RK_W; i++) begin
      rk[i] = cd[PC2[i]];
    end
  end

endmodule

`default_nettype wire

// File: rtl/des_iter_round_ctrl.sv
// ============================================================================
// des_iter_round_ctrl
// Iterative DES round sequencer. Holds L/R and C/D, runs 16 rounds through
// an external combinational f-function (one round per cycle) and presents
// R16||L16 (pre-FP) until the consumer takes it.
// Optional feature: define DES_SEQ_ABORT_EN to add the 'abort' input, which
// drops an in-flight or held block and clears L/R and C/D.
// Ports:
//   clk, rst_n           clock, asynchronous active-low reset
//   abort                (DES_SEQ_ABORT_EN only) discard current block
//   in_valid/in_ready    input handshake
//   in_decrypt           1 = decrypt key order
//   in_block [1:64]      post-IP data, in_key [1:56] post-PC-1 key
//   f_r [1:32], f_k [1:48], f_res [1:32]  shared f-function interface
//   out_valid/out_ready  output handshake, out_block [1:64] = R16||L16
//   busy                 high while rounds are running
//   round_idx [3:0]      current round minus one, 0 outside ROUND
// Revision: 1.0
// ============================================================================
`default_nettype none

module des_iter_round_ctrl
  import des_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst_n,
`ifdef DES_SEQ_ABORT_EN
  input  logic                  abort,
`endif
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic                  in_decrypt,
  input  logic [1:DES_BLK_W]    in_block,
  input  logic [1:DES_KEY_W]    in_key,
  output logic [1:DES_HALF_W]   f_r,
  output logic [1:DES_RK_W]     f_k,
  input  logic [1:DES_HALF_W]   f_res,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [1:DES_BLK_W]    out_block,
  output logic                  busy,
  output logic [3:0]            round_idx
);

  des_state_t         state, state_nxt;
  logic [1:DES_BLK_W] lr;
  logic [1:DES_KEY_W] cd;
  logic [1:DES_KEY_W] cd_step;
  logic [4:0]         cnt;
  logic               decrypt;
  logic [1:0]         shift;
  logic               last_round;
  logic               accept;
  logic               abort_req;
  logic               abort_act;

`ifdef DES_SEQ_ABORT_EN
  assign abort_req = abort;
`else
  assign abort_req = 1'b0;
`endif
  // Abort only acts on a block in flight or held; in IDLE it merely blocks accept.
  assign abort_act  = abort_req & (state != IDLE);

  assign in_ready   = ~abort_req & ((state == IDLE) | ((state == DONE) & out_ready));
  assign accept     = in_valid & in_ready;
  assign last_round = (cnt == 5'd16);

  // Encrypt pre-rotates on load, so after round r it rotates by SHIFT[r+1];
  // decrypt starts from C0/D0 (== C16/D16) and walks the schedule backwards.
  always_comb begin
    shift = 2'd0;
    if (!last_round) begin
      shift = decrypt ? shift_amt(5'd17 - cnt) : shift_amt(cnt + 5'd1);
    end
  end

  des_key_sched_step u_key_step (
    .cd      (cd),
    .shift   (shift),
    .decrypt (decrypt),
    .cd_next (cd_step),
    .rk      (f_k)
  );

  assign f_r       = lr[DES_HALF_W+1:DES_BLK_W];
  assign out_block = {lr[DES_HALF_W+1:DES_BLK_W], lr[1:DES_HALF_W]};
  assign round_idx = (state == ROUND) ? 4'(cnt - 5'd1) : 4'd0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    out_valid = 1'b0;
    busy      = 1'b0;
    case (state)
      IDLE: begin
        if (accept) state_nxt = ROUND;
      end
      ROUND: begin
        busy = 1'b1;
        if (last_round) state_nxt = DONE;
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) state_nxt = accept ? ROUND : IDLE;
      end
      default: state_nxt = IDLE;
    endcase
    if (abort_act) state_nxt = IDLE;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lr      <= '0;
      cd      <= '0;
      cnt     <= 5'd0;
      decrypt <= 1'b0;
    end else if (abort_act) begin
      lr  <= '0;
      cd  <= '0;
      cnt <= 5'd0;
    end else if (accept) begin
      lr      <= in_block;
      cnt     <= 5'd1;
      decrypt <= in_decrypt;
      if (in_decrypt) begin
        cd <= in_key;
      end else begin
        cd <= {rotl28(in_key[1:DES_CD_W], 2'd1), rotl28(in_key[DES_CD_W+1:DES_KEY_W], 2'd1)};
      end
    end else if (state == ROUND) begin
      lr <= {lr[DES_HALF_W+1:DES_BLK_W], lr[1:DES_HALF_W] ^ f_res};
      cd <= cd_step;
      if (!last_round) cnt <= cnt + 5'd1;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_des_iter_round_ctrl.sv
// ============================================================================
// tb_des_iter_round_ctrl
// Directed bench for des_iter_round_ctrl. Supplies the DES f-function
// (E, S-boxes, P) plus IP/FP/PC-1 conversions and checks known DES vectors,
// latency, backpressure, back-to-back flow and mid-round reset.
// With DES_SEQ_ABORT_EN defined the abort port is exercised as well.
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_des_iter_round_ctrl;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid, in_ready, in_decrypt;
  logic [1:64] in_block;
  logic [1:56] in_key;
  logic [1:32] f_r, f_res;
  logic [1:48] f_k;
  logic        out_valid, out_ready, busy;
  logic [1:64] out_block;
  logic [3:0]  round_idx;
`ifdef DES_SEQ_ABORT_EN
  logic        abort = 1'b0;
`endif

  int checks = 0;
  int passes = 0;

  always #5 clk = ~clk;

  des_iter_round_ctrl dut (
    .clk        (clk),
    .rst_n      (rst_n),
`ifdef DES_SEQ_ABORT_EN
    .abort      (abort),
`endif
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_decrypt (in_decrypt),
    .in_block   (in_block),
    .in_key     (in_key),
    .f_r        (f_r),
    .f_k        (f_k),
    .f_res      (f_res),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_block  (out_block),
    .busy       (busy),
    .round_idx  (round_idx)
  );

  // ---------------- DES reference tables ----------------
  localparam int IP_T [1:64] = '{
    58, 50, 42, 34, 26, 18, 10, 2, 60, 52, 44, 36, 28, 20, 12, 4,
    62, 54, 46, 38, 30, 22, 14, 6, 64, 56, 48, 40, 32, 24, 16, 8,
    57, 49, 41, 33, 25, 17,  9, 1, 59, 51, 43, 35, 27, 19, 11, 3,
    61, 53, 45, 37, 29, 21, 13, 5, 63, 55, 47, 39, 31, 23, 15, 7
  };
  localparam int PC1_T [1:56] = '{
    57, 49, 41, 33, 25, 17,  9,  1, 58, 50, 42, 34, 26, 18,
    10,  2, 59, 51, 43, 35, 27, 19, 11,  3, 60, 52, 44, 36,
    63, 55, 47, 39, 31, 23, 15,  7, 62, 54, 46, 38, 30, 22,
    14,  6, 61, 53, 45, 37, 29, 21, 13,  5, 28, 20, 12,  4
  };
  localparam int P_T [1:32] = '{
    16,  7, 20, 21, 29, 12, 28, 17,  1, 15, 23, 26,  5, 18, 31, 10,
     2,  8, 24, 14, 32, 27,  3,  9, 19, 13, 30,  6, 22, 11,  4, 25
  };
  // Each S-box: 64 nibbles, row-major (row = b1b6, column = b2..b5), first entry in the top nibble.
  localparam logic [255:0] SB [0:7] = '{
    256'hE4D12FB83A6C5907_0F74E2D1A6CB9538_41E8D62BFC973A50_FC8249175B3EA06D,
    256'hF18E6B34972DC05A_3D47F28EC01A69B5_0E7BA4D158C6932F_D8A13F42B67C05E9,
    256'hA09E63F51DC7B428_D709346A285ECBF1_D6498F30B12C5AE7_1AD069874FE3B52C,
    256'h7DE3069A1285BC4F_D8B56F03472C1AE9_A690CB7DF13E5284_3F06A1D8945BC72E,
    256'h2C417AB6853FD0E9_EB2C47D150FA3986_421BAD78F9C5630E_B8C71E2D6F09A453,
    256'hC1AF92680D34E75B_AF427C9561DE0B38_9EF528C3704A1DB6_432C95FABE17608D,
    256'h4B2EF08D3C975A61_D0B7491AE35C2F86_14BDC37EAF680592_6BD814A7950FE23C,
    256'hD2846FB1A93E50C7_1FD8A374C56B0E92_7B419CE206ADF358_21E74A8DFC90356B
  };

  function automatic logic [1:64] ip(input logic [1:64] x);
    logic [1:64] y;
    for (int i = 1; i <= 64; i++) y[i] = x[IP_T[i]];
    return y;
  endfunction

  function automatic logic [1:64] fp(input logic [1:64] x);
    logic [1:64] y;
    for (int i = 1; i <= 64; i++) y[IP_T[i]] = x[i];
    return y;
  endfunction

  function automatic logic [1:56] pc1(input logic [1:64] k);
    logic [1:56] y;
    for (int i = 1; i <= 56; i++) y[i] = k[PC1_T[i]];
    return y;
  endfunction

  function automatic logic [1:32] des_f(input logic [1:32] r, input logic [1:48] k);
    logic [1:48]  x;
    logic [1:32]  s;
    logic [1:32]  p;
    logic [5:0]   six;
    logic [255:0] row;
    int           n;
    for (int i = 0; i < 48; i++) x[i+1] = r[((4 * (i / 6) + (i % 6) + 31) % 32) + 1];
    x = x ^ k;
    for (int b = 0; b < 8; b++) begin
      six = x[6*b+1 +: 6];
      n   = 16 * int'({six[5], six[0]}) + int'(six[4:1]);
      row = SB[b];
      s[4*b+1 +: 4] = row[255-4*n -: 4];
    end
    for (int i = 1; i <= 32; i++) p[i] = s[P_T[i]];
    return p;
  endfunction

  always_comb f_res = des_f(f_r, f_k);

  // ---------------- checking ----------------
  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got === exp) passes++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  // Offers a block in IDLE; returns at the falling edge after the accepting edge.
  task automatic send(input logic [1:64] key, input logic [1:64] blk, input logic dec);
    @(negedge clk);
    check("send_ready", in_ready, 1'b1);
    in_valid   = 1'b1;
    in_key     = pc1(key);
    in_block   = ip(blk);
    in_decrypt = dec;
    @(negedge clk);
    in_valid   = 1'b0;
    in_key     = '1;
    in_block   = '1;
    in_decrypt = ~dec;
  endtask

  // Counts falling edges until out_valid, bounded at 40.
  task automatic wait_out(output int n);
    n = 0;
    while (!out_valid && n < 40) begin
      @(negedge clk);
      n++;
    end
  endtask

  localparam logic [1:64] KEY1 = 64'h133457799BBCDFF1;
  localparam logic [1:64] PT1  = 64'h0123456789ABCDEF;
  localparam logic [1:64] CT1  = 64'h85E813540F0AB405;
  localparam logic [1:64] KEY2 = 64'h0E329232EA6D0D73;
  localparam logic [1:64] PT2  = 64'h8787878787878787;
  localparam logic [1:64] CT2  = 64'h0000000000000000;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    int          n;
    int          m;
    logic [1:64] held;
    logic        seen;
    in_valid = 1'b0; in_decrypt = 1'b0; in_block = '0; in_key = '0; out_ready = 1'b0;
    seen = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // reset state
    check("rst_in_ready",  in_ready,  1'b1);
    check("rst_out_valid", out_valid, 1'b0);
    check("rst_busy",      busy,      1'b0);
    check("rst_round_idx", round_idx, 4'd0);
    check("rst_out_block", out_block, 64'h0);

    // encrypt with exact latency, then backpressure
    send(KEY1, PT1, 1'b0);
    check("enc_k1",    f_k,       48'h1B02EFFC7072);
    check("enc_busy",  busy,      1'b1);
    check("enc_ridx0", round_idx, 4'd0);
    n = 0;
    while (!out_valid && n < 40) begin
      @(negedge clk);
      n++;
      if (n == 7) check("enc_ridx7", round_idx, 4'd7);
      if (n == 15) check("enc_ridx15", round_idx, 4'd15);
    end
    check("enc_latency", 64'(n), 64'd16);
    check("enc_ct",      fp(out_block), CT1);
    held     = out_block;
    in_valid = 1'b1;
    in_key   = pc1(KEY2);
    in_block = ip(PT2);
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      check("bp_stable",   out_block, held);
      check("bp_in_ready", in_ready,  1'b0);
      check("bp_valid",    out_valid, 1'b1);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    check("bp_rel_valid", out_valid, 1'b0);
    check("bp_rel_ready", in_ready,  1'b1);
    check("bp_rel_busy",  busy,      1'b0);

    // decrypt
    send(KEY1, CT1, 1'b1);
    check("dec_k16", f_k, 48'hCB3D8B0E17F5);
    wait_out(n);
    check("dec_latency", 64'(n), 64'd16);
    check("dec_pt",      fp(out_block), PT1);
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    check("dec_drain", out_valid, 1'b0);

    // back-to-back with in_valid held high
    @(negedge clk);
    in_valid = 1'b1; in_key = pc1(KEY1); in_block = ip(PT1); in_decrypt = 1'b0;
    @(negedge clk);
    in_key = pc1(KEY2); in_block = ip(PT2); out_ready = 1'b1;
    check("b2b_busy_a", busy, 1'b1);
    wait_out(n);
    check("b2b_lat_a", 64'(n), 64'd16);
    check("b2b_ct_a",  fp(out_block), CT1);
    check("b2b_rdy",   in_ready, 1'b1);
    @(negedge clk);
    in_valid = 1'b0; in_key = '0; in_block = '0;
    check("b2b_busy_b",  busy,      1'b1);
    check("b2b_ridx_b",  round_idx, 4'd0);
    check("b2b_valid_b", out_valid, 1'b0);
    wait_out(m);
    check("b2b_spacing", 64'(m + 1), 64'd17);
    check("b2b_ct_b",    fp(out_block), CT2);
    @(negedge clk);
    out_ready = 1'b0;
    check("b2b_idle", in_ready & ~out_valid & ~busy, 1'b1);

    // reset in the middle of round 8
    send(KEY1, PT1, 1'b0);
    n = 0;
    while (round_idx != 4'd7 && n < 40) begin
      @(negedge clk);
      n++;
    end
    check("mid_reach7", 64'(n), 64'd7);
    rst_n = 1'b0;
    #1;
    check("mid_busy",  busy,      1'b0);
    check("mid_ridx",  round_idx, 4'd0);
    check("mid_valid", out_valid, 1'b0);
    check("mid_ready", in_ready,  1'b1);
    check("mid_block", out_block, 64'h0);
    check("mid_fk",    f_k,       48'h0);
    @(negedge clk);
    rst_n = 1'b1;
    send(KEY2, PT2, 1'b0);
    wait_out(n);
    check("mid_after_lat", 64'(n), 64'd16);
    check("mid_after_ct",  fp(out_block), CT2);
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;

`ifdef DES_SEQ_ABORT_EN
    // abort during round 10
    send(KEY1, PT1, 1'b0);
    n = 0;
    while (round_idx != 4'd9 && n < 40) begin
      @(negedge clk);
      n++;
    end
    abort = 1'b1;
    #1;
    check("ab_ready_low", in_ready, 1'b0);
    @(negedge clk);
    abort = 1'b0;
    check("ab_busy",  busy,      1'b0);
    check("ab_valid", out_valid, 1'b0);
    check("ab_clear", out_block, 64'h0);
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (out_valid) seen = 1'b1;
    end
    check("ab_never_valid", seen, 1'b0);

    // abort coincident with out handshake and a new offer
    send(KEY1, PT1, 1'b0);
    wait_out(n);
    check("ab2_ct", fp(out_block), CT1);
    out_ready = 1'b1; in_valid = 1'b1; in_key = pc1(KEY2); in_block = ip(PT2); abort = 1'b1;
    #1;
    check("ab2_ready", in_ready, 1'b0);
    @(negedge clk);
    abort = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    check("ab2_busy",  busy,      1'b0);
    check("ab2_valid", out_valid, 1'b0);
    check("ab2_idle",  in_ready,  1'b1);
`endif

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

`default_nettype wire
